// File: rtl/fifo_read_adapter_if.sv
// Output stream of the FIFO read adapter: valid/ready words with burst
// framing and a running delivered-word total.
interface fifo_read_adapter_if #(
  parameter int WORD = 8,
  parameter int CNTW = 16
);
  logic            out_valid;
  logic            out_ready;
  logic [WORD-1:0] out_data;
  logic            out_last;
  logic [CNTW-1:0] word_count;

  modport master (output out_valid, out_data, out_last, word_count, input out_ready);
  modport slave  (input out_valid, out_data, out_last, word_count, output out_ready);
endinterface

// File: rtl/fifo_read_adapter.sv
// Read-side consumer for an asynchronous FIFO. Pops whenever buffer space is
// guaranteed, absorbs the FIFO's one-cycle read latency in a small circular
// buffer, and re-presents the words on a valid/ready stream.
module fifo_read_adapter #(
  parameter int WORD  = 8,
  parameter int DEPTH = 3,
  parameter int BURST = 8,
  parameter int CNTW  = 16
) (
  input  logic            rclk,
  input  logic            rst,
  input  logic            drain_en,
  input  logic            fifo_empty,
  input  logic [WORD-1:0] fifo_rdata,
  output logic            fifo_ren,
  fifo_read_adapter_if.master stream
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 2);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEPTH);

  logic [DEPTH-1:0][WORD-1:0] mem;
  logic [PW-1:0]              head, tail;
  logic [CW-1:0]              count;
  logic                       inflight;
  logic [BW-1:0]              beat;
  logic [CNTW-1:0]            word_count;
  logic                       fire;

  // Pop only when the buffer can hold every word already requested plus this
  // one; uses registered state only, so out_ready never reaches fifo_ren.
  // Reset gating keeps the FIFO from being popped while the adapter is held.
  assign fifo_ren = !rst && drain_en && !fifo_empty &&
                    ((count + CW'(inflight)) < CNT_MAX);

  assign fire              = stream.out_valid && stream.out_ready;
  assign stream.out_valid  = (count != '0);
  assign stream.out_data   = mem[head];
  assign stream.out_last   = stream.out_valid && (beat == BEAT_LAST);
  assign stream.word_count = word_count;

  // Circular buffer: capture the word popped last cycle at the tail, retire
  // the head on fire; occupancy nets both so capture+fire leaves it unchanged.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      mem      <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_ren;
      if (inflight) begin
        mem[tail] <= fifo_rdata;
        tail      <= (tail == PTR_LAST) ? '0 : tail + PW'(1);
      end
      if (fire) head <= (head == PTR_LAST) ? '0 : head + PW'(1);
      count <= count + CW'(inflight) - CW'(fire);
    end
  end

  // Frame position and delivered-word total advance once per accepted word.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      beat       <= '0;
      word_count <= '0;
    end else if (fire) begin
      beat       <= (beat == BEAT_LAST) ? '0 : beat + BW'(1);
      word_count <= word_count + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_fifo_read_adapter.sv
// Directed bench for fifo_read_adapter: one default instance (BURST=8,
// CNTW=16) for streaming, back-pressure, drain and reset cases, and one
// BURST=3/CNTW=4 instance for framing and counter wrap.
module tb_fifo_read_adapter;
  logic rclk = 1'b0;
  logic rst  = 1'b1;
  always #5 rclk = ~rclk;

  logic       drain0 = 1'b0, drain1 = 1'b0;
  logic       ren0, ren1, empty0, empty1;
  logic [7:0] rdata0 = '0, rdata1 = '0;
  int         rptr0 = 0, wptr0 = 0, rptr1 = 0, wptr1 = 0;

  fifo_read_adapter_if #(.WORD(8), .CNTW(16)) s0 ();
  fifo_read_adapter_if #(.WORD(8), .CNTW(4))  s1 ();

  fifo_read_adapter #(.WORD(8), .DEPTH(3), .BURST(8), .CNTW(16)) u0 (
    .rclk(rclk), .rst(rst), .drain_en(drain0), .fifo_empty(empty0),
    .fifo_rdata(rdata0), .fifo_ren(ren0), .stream(s0));
  fifo_read_adapter #(.WORD(8), .DEPTH(3), .BURST(3), .CNTW(4)) u1 (
    .rclk(rclk), .rst(rst), .drain_en(drain1), .fifo_empty(empty1),
    .fifo_rdata(rdata1), .fifo_ren(ren1), .stream(s1));

  // FIFO models: registered read, word at index i holds i+1; not reset by rst
  assign empty0 = (rptr0 == wptr0);
  assign empty1 = (rptr1 == wptr1);
  always @(posedge rclk) begin
    if (ren0) begin rdata0 <= 8'(rptr0 + 1); rptr0 <= rptr0 + 1; end
    if (ren1) begin rdata1 <= 8'(rptr1 + 1); rptr1 <= rptr1 + 1; end
  end

  logic [7:0] got0[$], got1[$];
  bit         lst0[$], lst1[$];
  int nren0 = 0, bad_ren = 0, bad_cnt = 0;
  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Change inputs just after the active edge.
  task automatic drive_point();
    @(posedge rclk);
    #1;
  endtask

  // Sample one cycle on the falling edge.
  task automatic step();
    @(negedge rclk);
    if (s0.out_valid && s0.out_ready) begin got0.push_back(s0.out_data); lst0.push_back(s0.out_last); end
    if (s1.out_valid && s1.out_ready) begin got1.push_back(s1.out_data); lst1.push_back(s1.out_last); end
    if (ren0) nren0++;
    if ((ren0 && empty0) || (ren1 && empty1)) bad_ren++;
    if (u0.count > 3 || u1.count > 3) bad_cnt++;
  endtask

  initial begin
    int b, n;
    s0.out_ready = 1'b0;
    s1.out_ready = 1'b0;

    // reset state
    step(); step();
    chk("rst_ren", ren0, 0);
    chk("rst_valid", s0.out_valid, 0);
    chk("rst_last", s0.out_last, 0);
    chk("rst_data", s0.out_data, 0);
    chk("rst_wcnt", s0.word_count, 0);
    rst = 1'b0;

    // streaming of words 1..8 with ready high
    drive_point();
    wptr0 = 8; drain0 = 1'b1; s0.out_ready = 1'b1;
    step();
    chk("t1_ren_n", ren0, 1);
    chk("t1_valid_n", s0.out_valid, 0);
    step();
    chk("t1_valid_n1", s0.out_valid, 0);
    b = got0.size();
    step();
    chk("t1_valid_n2", s0.out_valid, 1);
    repeat (7) step();
    chk("t1_consec", got0.size() - b, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t1_data%0d", k), got0[b+k], k + 1);
      chk($sformatf("t1_last%0d", k), lst0[b+k], (k == 7) ? 1 : 0);
    end
    repeat (3) step();
    chk("t1_total", got0.size() - b, 8);
    chk("t1_wcnt", s0.word_count, 8);

    // back-pressure with 10 words (9..18) available
    drive_point();
    s0.out_ready = 1'b0; wptr0 += 10; n = nren0;
    repeat (3) step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_hold_valid", s0.out_valid, 1);
      chk("t2_hold_data", s0.out_data, 9);
      chk("t2_hold_last", s0.out_last, 0);
    end
    chk("t2_pops", nren0 - n, 3);
    chk("t2_count", u0.count, 3);
    drive_point();
    s0.out_ready = 1'b1; b = got0.size();
    step();
    repeat (9) step();
    chk("t2_nogap", got0.size() - b, 10);
    for (int k = 0; k < 10; k++) chk($sformatf("t2_data%0d", k), got0[b+k], 9 + k);
    repeat (4) step();
    chk("t2_total", got0.size() - b, 10);
    chk("t2_wcnt", s0.word_count, 18);

    // ready toggling every cycle over 20 words (19..38)
    drive_point();
    wptr0 += 20; b = got0.size();
    s0.out_ready = 1'b0;
    step();
    for (int c = 0; c < 60; c++) begin
      drive_point();
      s0.out_ready = ~s0.out_ready;
      step();
    end
    chk("t3_cnt", got0.size() - b, 20);
    for (int k = 0; k < 20; k++) chk($sformatf("t3_data%0d", k), got0[b+k], 19 + k);
    chk("t3_overflow", bad_cnt, 0);
    chk("t3_underflow_pop", bad_ren, 0);

    // drain_en dropped just after a pop (words 39..43)
    drive_point();
    s0.out_ready = 1'b1; drain0 = 1'b0; wptr0 += 5;
    step();
    chk("t4_idle_ren", ren0, 0);
    drive_point();
    drain0 = 1'b1;
    #1;
    chk("t4_ren", ren0, 1);
    drive_point();
    drain0 = 1'b0; n = nren0; b = got0.size();
    step();
    repeat (5) step();
    chk("t4_no_pop", nren0 - n, 0);
    chk("t4_inflight_cnt", got0.size() - b, 1);
    chk("t4_inflight_word", got0[b], 39);
    drive_point();
    drain0 = 1'b1; n = nren0; b = got0.size();
    step();
    repeat (9) step();
    chk("t4_resume_pops", nren0 - n, 4);
    chk("t4_resume_cnt", got0.size() - b, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("t4_data%0d", k), got0[b+k], 40 + k);

    // async reset mid-stream with a word in flight (words 44..55)
    drive_point();
    wptr0 += 12; b = got0.size();
    step(); step(); step(); step();
    chk("t5_pre_cnt", got0.size() - b, 2);
    chk("t5_pre_w0", got0[b], 44);
    chk("t5_pre_w1", got0[b+1], 45);
    drive_point();
    chk("t5_inflight", u0.inflight, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_ren", ren0, 0);
    chk("t5_rst_valid", s0.out_valid, 0);
    chk("t5_rst_last", s0.out_last, 0);
    chk("t5_rst_data", s0.out_data, 0);
    chk("t5_rst_wcnt", s0.word_count, 0);
    step(); step();
    drive_point();
    rst = 1'b0; b = got0.size();
    repeat (14) step();
    chk("t5_post_cnt", got0.size() - b, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t5_data%0d", k), got0[b+k], 48 + k);
      chk($sformatf("t5_last%0d", k), lst0[b+k], (k == 7) ? 1 : 0);
    end
    chk("t5_wcnt", s0.word_count, 8);

    // BURST=3 framing and 4-bit counter wrap over 17 words
    drive_point();
    wptr1 = 17; drain1 = 1'b1; s1.out_ready = 1'b1;
    repeat (25) step();
    chk("t6_cnt", got1.size(), 17);
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("t6_data%0d", k), got1[k], k + 1);
      chk($sformatf("t6_last%0d", k), lst1[k], ((k + 1) % 3 == 0) ? 1 : 0);
    end
    chk("t6_wcnt_wrap", s1.word_count, 1);
    chk("final_overflow", bad_cnt, 0);
    chk("final_underflow_pop", bad_ren, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fifo_read_adapter.md
# fifo_read_adapter

Read-side consumer that sits directly downstream of the asynchronous FIFO in the `rclk` domain. It issues FIFO pops whenever space is guaranteed and absorbs the FIFO's one-cycle registered read latency in a small internal buffer. It re-presents the words on a valid/ready stream with burst framing (`out_last`) and a running delivered-word count. Downstream logic never has to see `ren`/`empty` timing.

## Interface
Parameters:
- `WORD`, 8, data width; must match the FIFO word width.
- `DEPTH`, 3, internal buffer entries; minimum 3, which is required for full throughput.
- `BURST`, 8, words per frame; `out_last` marks every BURST-th word; minimum 1.
- `CNTW`, 16, width of `word_count`.

Ports (one clock; reset is asynchronous and active-high):
- `rclk`  in  1  read-domain clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `drain_en`  in  1  permits new pops when high; does not stop delivery of buffered or in-flight words.
- `fifo_empty`  in  1  FIFO empty flag (registered in the `rclk` domain).
- `fifo_rdata`  in  WORD  FIFO read data; valid in the cycle after a pop.
- `fifo_ren`  out  1  pop request to the FIFO.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  WORD  head-of-buffer word.
- `out_last`  out  1  the current word is the last of a BURST-word frame.
- `word_count`  out  CNTW  total words accepted downstream; wraps modulo 2^CNTW.

## Operation
- State:
  - `count` (0..DEPTH), the buffer occupancy.
  - `inflight` (1 bit), a registered copy of `fifo_ren`.
  - `beat` (0..BURST-1), the position within the current frame.
  - `word_count`.
  - Circular buffer with head and tail pointers, each wrapping at DEPTH.
- Pop rule: `fifo_ren = drain_en && !fifo_empty && (count + inflight < DEPTH)`.
  - Only registered state and `fifo_empty` feed this rule.
  - There is no combinational path from `out_ready` to `fifo_ren`.
- Capture: when `inflight` = 1, `fifo_rdata` is written at the tail on the next edge and the tail advances.
- Fire: when `out_valid && out_ready`, the head advances, `word_count` increments, and `beat` increments.
  - `beat` wraps to 0 after BURST-1.
- Occupancy update when capture and fire happen in the same cycle:
  - `count` is unchanged.
  - Data ordering is preserved; the head word leaves before the new tail word becomes visible.
- Outputs:
  - `out_valid = (count != 0)`.
  - `out_data` = buffer[head].
  - `out_last = out_valid && (beat == BURST-1)`.
- Overflow is impossible by the pop rule. An overflow is a design error, and the bench asserts that `count` never exceeds DEPTH.
- A FIFO underflow pop is never issued, because `fifo_ren` requires `!fifo_empty`.
- `drain_en` deassert: pops stop in the same cycle. Any in-flight word is still captured, and the buffer keeps draining.

## Timing
- Reset (asynchronous assert, synchronous-release behaviour on the next `rclk` edge):
  - `fifo_ren` = 0, `out_valid` = 0, `out_last` = 0.
  - `out_data` = 0, `word_count` = 0.
  - `count` = 0, `inflight` = 0, `beat` = 0, head and tail = 0.
- Reset during operation: an in-flight word is discarded. The FIFO pointer has already advanced, so that word is lost; this is accepted behaviour.
- Latency:
  - `fifo_empty` falls in cycle N → `fifo_ren` is high in cycle N.
  - The word is captured at the end of cycle N+1.
  - `out_valid` is high in cycle N+2.
- Throughput: with `out_ready` held high and the FIFO non-empty, steady-state delivery is 1 word per cycle.
- Back-pressure: `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- Wrap-around:
  - Buffer pointers wrap modulo DEPTH.
  - `word_count` rolls from 2^CNTW-1 to 0.
  - `beat` rolls from BURST-1 to 0.

## Test plan
- Reset, then FIFO pre-loaded with words 1..8, `drain_en`=1, `out_ready`=1:
  - First `out_valid` appears 2 cycles after the first `fifo_ren`.
  - Words 1..8 are delivered in consecutive cycles.
  - `out_last` is high only on word 8.
  - `word_count`=8.
- Back-pressure: `out_ready`=0 with 10 words available:
  - `fifo_ren` asserts exactly 3 times; `count` reaches 3.
  - `out_data`=1 is held stable.
  - Releasing `out_ready` delivers 1,2,3,… in order with no gaps or duplicates.
- Simultaneous capture and fire: `out_ready` toggles every cycle over 20 words:
  - The output sequence is exactly 1..20.
  - `count` never exceeds 3.
  - `fifo_ren` is never asserted while `fifo_empty`=1.
- `drain_en` dropped mid-stream, just after a pop:
  - The in-flight word is still delivered.
  - No further `fifo_ren` is issued.
  - Re-enabling resumes with the next FIFO word.
- Wrap and framing with BURST=3 and CNTW=4, 17 words:
  - `out_last` is high on words 3,6,9,12,15.
  - `word_count` reads 1 after word 17 (wrapped).
- Asynchronous `rst` pulse asserted mid-stream while `inflight`=1:
  - All outputs go to 0 immediately without a clock edge.
  - After release, delivery restarts from the next FIFO word with `beat`=0 and `word_count`=0.
